// File: rtl/digi_scan_driver.sv
// Memory-mapped four-digit seven-segment scanner: VALUE/CTRL registers, frame-aligned
// display shadow, digit multiplexing and hex decode onto {an, seg}, all active-low.
`timescale 1ns/1ps
module digi_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter logic [31:0] BASE_ADDR = 32'h40000014
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_wr,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic [11:0] digi
);

  localparam int unsigned DIV_W     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned VAL_W     = 16;
  localparam int unsigned CTRL_W    = 9;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [31:0]  CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CTRL_W-1:0] CTRL_RST = 9'h00F;
  localparam logic [11:0]  DIGI_RST  = 12'hEC0;
  localparam logic [11:0]  DIGI_OFF  = 12'hFFF;

  logic [VAL_W-1:0]  value_q, value_nxt, shadow_value_q;
  logic [CTRL_W-1:0] ctrl_q, ctrl_nxt, shadow_ctrl_q;
  logic [DIV_W-1:0]  div_q;
  logic [1:0]        idx_q;
  logic              wr_value, wr_ctrl, div_tc, boundary;
  logic [3:0]        nibble, en_mask, dp_mask;
  logic [6:0]        pattern;
  logic              lz_blank, blank;
  logic [11:0]       digi_nxt;
  logic              unused_wdata;

  assign unused_wdata = &{1'b0, Write_data[31:16]};

  // Register write decode; the written value is what a coincident boundary captures.
  always_comb begin
    wr_value  = ex_wr && (Address == BASE_ADDR);
    wr_ctrl   = ex_wr && (Address == CTRL_ADDR);
    value_nxt = wr_value ? Write_data[VAL_W-1:0] : value_q;
    ctrl_nxt  = wr_ctrl ? Write_data[CTRL_W-1:0] : ctrl_q;
    div_tc    = (div_q == DIV_LAST);
    boundary  = div_tc && (idx_q == 2'd3);
  end

  always_comb begin
    Read_data = 32'd0;
    if (Address == BASE_ADDR) Read_data = 32'(value_q);
    else if (Address == CTRL_ADDR) Read_data = 32'(ctrl_q);
  end

  // Slot decode from the shadow: nibble select, leading-zero test, segment pattern.
  always_comb begin
    nibble   = shadow_value_q[3:0];
    lz_blank = 1'b0;
    en_mask  = shadow_ctrl_q[3:0];
    dp_mask  = shadow_ctrl_q[7:4];
    case (idx_q)
      2'd1: begin
        nibble   = shadow_value_q[7:4];
        lz_blank = (shadow_value_q[15:4] == 12'd0);
      end
      2'd2: begin
        nibble   = shadow_value_q[11:8];
        lz_blank = (shadow_value_q[15:8] == 8'd0);
      end
      2'd3: begin
        nibble   = shadow_value_q[15:12];
        lz_blank = (shadow_value_q[15:12] == 4'd0);
      end
      default: ;
    endcase
    case (nibble)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
    blank    = !en_mask[idx_q] || (shadow_ctrl_q[8] && lz_blank);
    digi_nxt = blank ? DIGI_OFF
                     : {~(4'b0001 << idx_q), ~{dp_mask[idx_q], pattern}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q        <= '0;
      ctrl_q         <= CTRL_RST;
      shadow_value_q <= '0;
      shadow_ctrl_q  <= CTRL_RST;
      div_q          <= '0;
      idx_q          <= 2'd0;
      digi           <= DIGI_RST;
    end else begin
      value_q <= value_nxt;
      ctrl_q  <= ctrl_nxt;
      if (div_tc) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (boundary) begin
        shadow_value_q <= value_nxt;
        shadow_ctrl_q  <= ctrl_nxt;
      end
      digi <= digi_nxt;
    end
  end

endmodule

// File: tb/tb_digi_scan_driver.sv
// Directed bench for digi_scan_driver with SCAN_DIV=4 (16-cycle frames).
`timescale 1ns/1ps
module tb_digi_scan_driver;

  localparam int unsigned SCAN_DIV  = 4;
  localparam logic [31:0] BASE_ADDR = 32'h40000014;
  localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;
  localparam int          FRAME     = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_wr;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic [11:0] digi;

  int checks = 0;
  int errors = 0;
  int e = 0;  // rising edges since the last edge with reset sampled high

  digi_scan_driver #(.SCAN_DIV(SCAN_DIV), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .reset(reset), .ex_wr(ex_wr), .Address(Address),
    .Write_data(Write_data), .Read_data(Read_data), .digi(digi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto_edge(input int t);
    while (e < t) tick();
  endtask

  function automatic int next_boundary();
    return ((e / FRAME) + 1) * FRAME;
  endfunction

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    ex_wr = 1'b1; Address = addr; Write_data = data;
    tick();
    ex_wr = 1'b0; Address = BASE_ADDR; Write_data = 32'd0;
  endtask

  task automatic test_reset();
    logic [11:0] exp [4];
    exp = '{12'hEC0, 12'hDC0, 12'hBC0, 12'h7C0};
    reset = 1'b1; ex_wr = 1'b0; Address = BASE_ADDR; Write_data = 32'd0;
    tick(); tick();
    reset = 1'b0; e = 0;
    checks++;
    if (digi !== 12'hEC0) begin
      errors++; $display("FAIL reset_digi: got %h want EC0", digi);
    end
    checks++;
    if (Read_data !== 32'd0) begin
      errors++; $display("FAIL reset_value: got %h want 0", Read_data);
    end
    Address = CTRL_ADDR; #1;
    checks++;
    if (Read_data !== 32'h0000000F) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0000000F", Read_data);
    end
    Address = BASE_ADDR;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (digi !== exp[((e - 1) / 4) % 4]) begin
        errors++; $display("FAIL reset_scan e=%0d: got %h want %h", e, digi, exp[((e - 1) / 4) % 4]);
      end
    end
  endtask

  task automatic test_value_1234();
    logic [11:0] exp [4];
    int b;
    exp = '{12'hE99, 12'hDB0, 12'hBA4, 12'h7F9};
    wr(BASE_ADDR, 32'h00001234);
    checks++;
    if (Read_data !== 32'h00001234) begin
      errors++; $display("FAIL value_readback: got %h want 00001234", Read_data);
    end
    b = next_boundary();
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + 1 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL v1234_first d%0d: got %h want %h", k, digi, exp[k]);
      end
      goto_edge(b + 4 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL v1234_last d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
  endtask

  task automatic test_blank_lz();
    logic [11:0] exp [4];
    int b;
    exp = '{12'hEC0, 12'hD92, 12'hFFF, 12'hFFF};
    wr(CTRL_ADDR, 32'h0000010F);
    wr(BASE_ADDR, 32'h00000050);
    b = next_boundary();
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + 2 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL blank_lz d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
  endtask

  task automatic test_enable_dp();
    logic [11:0] exp [4];
    int b;
    exp = '{12'hEC0, 12'hFFF, 12'hBC0, 12'hFFF};
    wr(CTRL_ADDR, 32'h00000025);
    Address = CTRL_ADDR; #1;
    checks++;
    if (Read_data !== 32'h00000025) begin
      errors++; $display("FAIL ctrl_readback: got %h want 00000025", Read_data);
    end
    Address = BASE_ADDR;
    b = next_boundary();
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + 3 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL enable_mask d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
    exp = '{12'hEC0, 12'hD12, 12'hBC0, 12'h7C0};
    wr(CTRL_ADDR, 32'h0000002F);
    b = next_boundary();
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + 1 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL dp_enabled d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
  endtask

  task automatic test_shadow();
    logic [11:0] exp [4];
    int b;
    b = next_boundary();
    goto_edge(b + 5);
    wr(BASE_ADDR, 32'h0000FFFF);
    checks++;
    if (Read_data !== 32'h0000FFFF) begin
      errors++; $display("FAIL midframe_readback: got %h want 0000FFFF", Read_data);
    end
    goto_edge(b + 9);
    checks++;
    if (digi !== 12'hBC0) begin
      errors++; $display("FAIL midframe_d2: got %h want BC0", digi);
    end
    goto_edge(b + 13);
    checks++;
    if (digi !== 12'h7C0) begin
      errors++; $display("FAIL midframe_d3: got %h want 7C0", digi);
    end
    exp = '{12'hE8E, 12'hD0E, 12'hB8E, 12'h78E};
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + FRAME + 1 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL newframe d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
    b = next_boundary();
    goto_edge(b - 1);
    wr(BASE_ADDR, 32'h00000008);
    exp = '{12'hE80, 12'hD40, 12'hBC0, 12'h7C0};
    for (int k = 0; k < 4; k++) begin
      goto_edge(b + 1 + 4 * k);
      checks++;
      if (digi !== exp[k]) begin
        errors++; $display("FAIL coincident_wr d%0d: got %h want %h", k, digi, exp[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int b;
    b = next_boundary();
    goto_edge(b + 9);
    reset = 1'b1; ex_wr = 1'b1; Address = BASE_ADDR; Write_data = 32'h0000ABCD;
    tick();
    reset = 1'b0; ex_wr = 1'b0; Write_data = 32'd0; e = 0;
    checks++;
    if (Read_data !== 32'd0) begin
      errors++; $display("FAIL rst_drop_write: got %h want 0", Read_data);
    end
    checks++;
    if (digi !== 12'hEC0) begin
      errors++; $display("FAIL rst_mid_digi: got %h want EC0", digi);
    end
    Address = CTRL_ADDR; #1;
    checks++;
    if (Read_data !== 32'h0000000F) begin
      errors++; $display("FAIL rst_mid_ctrl: got %h want 0000000F", Read_data);
    end
    Address = BASE_ADDR + 32'd8; #1;
    checks++;
    if (Read_data !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: got %h want 0", Read_data);
    end
    Address = BASE_ADDR;
    goto_edge(4);
    checks++;
    if (digi !== 12'hEC0) begin
      errors++; $display("FAIL rst_mid_d0: got %h want EC0", digi);
    end
    goto_edge(5);
    checks++;
    if (digi !== 12'hDC0) begin
      errors++; $display("FAIL rst_mid_d1: got %h want DC0", digi);
    end
  endtask

  initial begin
    test_reset();
    test_value_1234();
    test_blank_lz();
    test_enable_dp();
    test_shadow();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
